// File: rtl/procesador_multiciclo_if.sv
// Shared instruction/data memory port with req/ack handshake.
// The core holds req/we/addr/wdata stable until the cycle in which ack is seen.
interface procesador_multiciclo_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/procesador_multiciclo.sv
// Multicycle ARM-subset core: DP/LDR/STR/B with condition codes, sticky
// undefined-instruction trap and a combinational debug register read port.
//  state  | meaning
//  FETCH  | request instruction at PC, latch IR on ack, PC += 4
//  DECODE | read operands, evaluate cond, dispatch or trap
//  EXEC   | ALU operation, optional NZCV update
//  ALUWB  | write Rd (or PC), retire
//  MEMADR | compute Rn +/- imm12
//  MEMRD  | load request until ack
//  MEMWB  | write loaded word to Rd (or PC), retire
//  MEMWR  | store request until ack, retire
//  BRANCH | PC <= target, retire
//  TRAP   | undefined instruction, parked until reset
module procesador_multiciclo #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  procesador_multiciclo_if.master mem,
  input  logic                   halt,
  input  logic [3:0]             dbg_sel,
  output logic [31:0]            dbg_data,
  output logic [ADDR_W-1:0]      pc_out,
  output logic                   retire,
  output logic                   trap
);

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_TRAP
  } state_t;

  state_t            state;
  logic [31:0]       rf [16];
  logic [ADDR_W-1:0] pc, maddr;
  logic [31:0]       ir, op_a, op_b, st_data, alu_q, ld_data;
  logic              n_f, z_f, c_f, v_f;
  logic              fetch_busy;

  logic [3:0]  cond, cmd, rn, rd, rm;
  logic [1:0]  op;
  logic        cond_ok, undef, req_fetch;
  logic [31:0] r15_val, rn_val, rm_val, rd_val, ea, br_tgt;
  logic [32:0] sum, dif;
  logic [31:0] alu_res;
  logic        alu_c, alu_v;

  assign cond = ir[31:28];
  assign op   = ir[27:26];
  assign cmd  = ir[24:21];
  assign rn   = ir[19:16];
  assign rd   = ir[15:12];
  assign rm   = ir[3:0];

  // R15 as an operand is the instruction address + 8; PC already holds +4 here.
  assign r15_val = 32'(pc + ADDR_W'(4));
  assign rn_val  = (rn == 4'd15) ? r15_val : rf[rn];
  assign rm_val  = (rm == 4'd15) ? r15_val : rf[rm];
  assign rd_val  = (rd == 4'd15) ? r15_val : rf[rd];
  assign ea      = ir[23] ? op_a + 32'(ir[11:0]) : op_a - 32'(ir[11:0]);
  assign br_tgt  = r15_val + {{6{ir[23]}}, ir[23:0], 2'b00};

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f && !z_f;
      4'h9: cond_ok = !c_f || z_f;
      4'hA: cond_ok = (n_f == v_f);
      4'hB: cond_ok = (n_f != v_f);
      4'hC: cond_ok = !z_f && (n_f == v_f);
      4'hD: cond_ok = z_f || (n_f != v_f);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign undef = (op == 2'b11) ||
                 ((op == 2'b00) && !(cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR}));

  always_comb begin
    sum     = {1'b0, op_a} + {1'b0, op_b};
    dif     = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;
    alu_res = '0;
    alu_c   = c_f;
    alu_v   = v_f;
    case (cmd)
      CMD_ADD: begin
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      CMD_SUB, CMD_CMP: begin
        alu_res = dif[31:0];
        alu_c   = dif[32];
        alu_v   = (op_a[31] != op_b[31]) && (dif[31] != op_a[31]);
      end
      CMD_AND: alu_res = op_a & op_b;
      CMD_ORR: alu_res = op_a | op_b;
      default: alu_res = '0;
    endcase
  end

  // Once a fetch request is out it stays out until ack, even if halt rises.
  assign req_fetch = (state == S_FETCH) && (!halt || fetch_busy);

  assign mem.req   = !rst && (req_fetch || state == S_MEMRD || state == S_MEMWR);
  assign mem.we    = (state == S_MEMWR);
  assign mem.addr  = (state == S_FETCH) ? (pc & ALIGN) : maddr;
  assign mem.wdata = st_data;

  assign dbg_data = (dbg_sel == 4'd15) ? 32'(pc) : rf[dbg_sel];
  assign pc_out   = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      {n_f, z_f, c_f, v_f} <= 4'b0000;
      ir         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      st_data    <= '0;
      alu_q      <= '0;
      ld_data    <= '0;
      maddr      <= '0;
      fetch_busy <= 1'b0;
      retire     <= 1'b0;
      trap       <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (req_fetch) begin
            if (mem.ack) begin
              ir         <= mem.rdata;
              pc         <= pc + ADDR_W'(4);
              fetch_busy <= 1'b0;
              state      <= S_DECODE;
            end else begin
              fetch_busy <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          op_a    <= rn_val;
          op_b    <= ir[25] ? 32'(ir[7:0]) : rm_val;
          st_data <= rd_val;
          if (!cond_ok) begin
            retire <= 1'b1;
            state  <= S_FETCH;
          end else if (undef) begin
            trap  <= 1'b1;
            state <= S_TRAP;
          end else begin
            case (op)
              2'b00:   state <= S_EXEC;
              2'b01:   state <= S_MEMADR;
              default: state <= S_BRANCH;
            endcase
          end
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (ir[20] || cmd == CMD_CMP)
            {n_f, z_f, c_f, v_f} <= {alu_res[31], (alu_res == '0), alu_c, alu_v};
          state <= S_ALUWB;
        end
        S_ALUWB: begin
          if (cmd != CMD_CMP) begin
            if (rd == 4'd15) pc <= ADDR_W'(alu_q) & ALIGN;
            else             rf[rd] <= alu_q;
          end
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_MEMADR: begin
          maddr <= ADDR_W'(ea) & ALIGN;
          state <= ir[20] ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          if (mem.ack) begin
            ld_data <= mem.rdata;
            state   <= S_MEMWB;
          end
        end
        S_MEMWB: begin
          if (rd == 4'd15) pc <= ADDR_W'(ld_data) & ALIGN;
          else             rf[rd] <= ld_data;
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_MEMWR: begin
          if (mem.ack) begin
            retire <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_BRANCH: begin
          pc     <= ADDR_W'(br_tgt) & ALIGN;
          retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_procesador_multiciclo.sv
// Directed bench: program in a behavioural memory with wait states on data
// accesses (address >= 0x80), table of per-retire expectations, plus hand sequences.
module tb_procesador_multiciclo;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          halt = 1'b0;
  logic [3:0]    dbg_sel = 4'd0;
  logic [31:0]   dbg_data;
  logic [AW-1:0] pc_out;
  logic          retire, trap;

  procesador_multiciclo_if #(.ADDR_W(AW)) bus ();

  procesador_multiciclo #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .mem(bus.master), .halt(halt),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc_out(pc_out),
    .retire(retire), .trap(trap)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [64];
  int          wait_states = 3;
  int          wcnt = 0;
  int          run = 0;
  int          last_run = 0;
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;

  assign bus.ack   = bus.req && ((bus.addr < 16'h80) || (wcnt >= wait_states));
  assign bus.rdata = mem_arr[bus.addr[7:2]];

  always @(posedge clk) begin
    if (bus.req && !bus.ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
    if (ld_en) mem_arr[ld_idx] <= ld_val;
    else if (bus.req && bus.ack && bus.we) mem_arr[bus.addr[7:2]] <= bus.wdata;
    if (bus.req && bus.addr >= 16'h80) begin
      run <= run + 1;
      if (bus.ack) last_run <= run + 1;
    end else begin
      run <= 0;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] val);
    ld_en  = 1'b1;
    ld_idx = 6'(idx);
    ld_val = val;
    @(posedge clk); #1;
    ld_en  = 1'b0;
  endtask

  task automatic wait_retire(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!retire && n < 60);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] val;
    int          cyc;
    int          run;
  } vec_t;

  vec_t vt [17];

  initial begin
    int n, bad;
    logic [AW-1:0] pc_hold;

    // per retired instruction: debug register, its value, cycles since last retire, data req length
    vt[0]  = '{4'd1,  32'h5,        4, 0};  // ADD R1,R0,#5
    vt[1]  = '{4'd2,  32'h8,        4, 0};  // ADD R2,R1,#3
    vt[2]  = '{4'd3,  32'h0,        4, 0};  // SUBS R3,R1,R1
    vt[3]  = '{4'd15, 32'h10,       2, 0};  // BNE not taken
    vt[4]  = '{4'd2,  32'h8,        7, 4};  // STR R2,[R0,#0x80]
    vt[5]  = '{4'd4,  32'h8,        8, 4};  // LDR R4,[R0,#0x80]
    vt[6]  = '{4'd5,  32'hFFFFFFFF, 4, 0};  // SUBS R5,R0,#1
    vt[7]  = '{4'd6,  32'h15,       4, 0};  // ADDMI R6,R1,#0x10
    vt[8]  = '{4'd7,  32'h0,        2, 0};  // ADDPL skipped
    vt[9]  = '{4'd8,  32'h0,        4, 0};  // ADDS R8,R5,#1
    vt[10] = '{4'd9,  32'hD,        4, 0};  // ORR R9,R1,R2
    vt[11] = '{4'd10, 32'h4,        4, 0};  // AND R10,R9,#6
    vt[12] = '{4'd0,  32'h0,        4, 0};  // CMP R1,#5
    vt[13] = '{4'd11, 32'h3C,       4, 0};  // ADDEQ R11,R15,#0
    vt[14] = '{4'd15, 32'h44,       3, 0};  // BEQ taken over two undefs
    vt[15] = '{4'd15, 32'h44,       3, 0};  // B . (imm24 = -2)
    vt[16] = '{4'd15, 32'h44,       3, 0};

    load(0,  32'hE2801005);
    load(1,  32'hE2812003);
    load(2,  32'hE0513001);
    load(3,  32'h1A000005);
    load(4,  32'hE4802080);
    load(5,  32'hE4904080);
    load(6,  32'hE2505001);
    load(7,  32'h42816010);
    load(8,  32'h52817001);
    load(9,  32'hE2958001);
    load(10, 32'hE1819002);
    load(11, 32'hE209A006);
    load(12, 32'hE3510005);
    load(13, 32'h028FB000);
    load(14, 32'h0A000001);
    load(15, 32'hEC000000);
    load(16, 32'hEC000000);
    load(17, 32'hEAFFFFFE);
    load(32, 32'h0);

    check("reset pc", 32'(pc_out), 32'h0);
    check("reset req", 32'(bus.req), 32'h0);
    check("reset retire", 32'(retire), 32'h0);
    check("reset trap", 32'(trap), 32'h0);
    dbg_sel = 4'd1; #1;
    check("reset r1", dbg_data, 32'h0);

    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      wait_retire(n);
      check($sformatf("v%0d cycles", i), 32'(n), 32'(vt[i].cyc));
      dbg_sel = vt[i].sel; #1;
      check($sformatf("v%0d r%0d", i, vt[i].sel), dbg_data, vt[i].val);
      if (vt[i].run != 0)
        check($sformatf("v%0d req length", i), 32'(last_run), 32'(vt[i].run));
      if (i == 4) check("store word 0x80", mem_arr[32], 32'h8);
    end

    // halt while parked in FETCH: no request, PC frozen
    halt = 1'b1;
    pc_hold = pc_out;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.req !== 1'b0 || pc_out !== pc_hold) bad++;
    end
    check("halt idle", 32'(bad), 32'h0);
    check("halt pc", 32'(pc_out), 32'h44);
    halt = 1'b0;
    wait_retire(n);
    check("resume cycles", 32'(n), 32'd3);

    // reset while a load waits for ack
    rst = 1'b1;
    load(0, 32'hE4904080);
    load(32, 32'h00001234);
    @(negedge clk); rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(bus.req && bus.addr == 16'h80) && n < 20);
    check("reach memrd", 32'(n < 20), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("rst drops req", 32'(bus.req), 32'h0);
    check("rst pc", 32'(pc_out), 32'h0);
    dbg_sel = 4'd4; #1;
    check("rst r4", dbg_data, 32'h0);

    // undefined instruction trap
    load(0, 32'hEC000000);
    @(negedge clk); rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!trap && n < 20);
    check("trap latency", 32'(n), 32'd2);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.req !== 1'b0 || trap !== 1'b1 || retire !== 1'b0) bad++;
    end
    check("trap parked", 32'(bad), 32'h0);
    rst = 1'b1; #1;
    check("trap cleared", 32'(trap), 32'h0);
    check("trap rst pc", 32'(pc_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
